// File: rtl/branch_fwd_ctrl_pkg.sv
// Shared constants for the decode-stage branch forwarding controller:
// forwarding-select encodings and the select priority helper.
package branch_fwd_ctrl_pkg;

  // Forwarding select encoding seen by the branch comparator muxes.
  // 2'b11 is never produced.
  localparam logic [1:0] FUB_RF  = 2'b00;  // register file read value
  localparam logic [1:0] FUB_MEM = 2'b01;  // mem_out, write-back value of the W-slot instruction
  localparam logic [1:0] FUB_ALU = 2'b10;  // alu_out latched for the M-slot instruction

  // Nearest usable producer wins: a non-load in M beats anything in W.
  // A load in M cannot forward (its data is not ready), so W is considered next.
  function automatic logic [1:0] fub_select(input logic hit_m,
                                            input logic hit_m_load,
                                            input logic hit_w);
    if (hit_m && !hit_m_load) begin
      return FUB_ALU;
    end else if (hit_w) begin
      return FUB_MEM;
    end else begin
      return FUB_RF;
    end
  endfunction

endpackage

// File: rtl/branch_fwd_ctrl_if.sv
// Decode-side bundle for the branch forwarding controller: decode
// instruction info in, forwarding selects / stall / stall counter out.
interface branch_fwd_ctrl_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);

  logic                   id_valid;
  logic                   id_is_branch;
  logic                   id_is_load;
  logic                   id_reg_write;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   flush;
  logic [1:0]             fub_cs_1;
  logic [1:0]             fub_cs_2;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Decoder / pipeline control side
  modport master (
    output id_valid, id_is_branch, id_is_load, id_reg_write, id_rd,
           id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, flush,
    input  fub_cs_1, fub_cs_2, stall, stall_cnt
  );

  // Forwarding controller side
  modport slave (
    input  id_valid, id_is_branch, id_is_load, id_reg_write, id_rd,
           id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, flush,
    output fub_cs_1, fub_cs_2, stall, stall_cnt
  );

endinterface

// File: rtl/branch_fwd_ctrl_fwd_src_match.sv
// Pure comparison of one decode source register against the E, M and W
// shadow slots. Producer flags already exclude invalid entries and rd == x0,
// so x0 can never match.
module fwd_src_match
  import branch_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  e_prod,
  input  logic                  e_is_load,
  input  logic [REG_ADDR_W-1:0] e_rd,
  input  logic                  m_prod,
  input  logic                  m_is_load,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  w_prod,
  input  logic [REG_ADDR_W-1:0] w_rd,
  output logic                  hit_e,
  output logic                  hit_e_load,
  output logic                  hit_m,
  output logic                  hit_m_load,
  output logic                  hit_w
);

  // Per-slot match of this source, plus load qualifiers for stall decisions
  always_comb begin
    hit_e      = uses && e_prod && (e_rd == rs);
    hit_m      = uses && m_prod && (m_rd == rs);
    hit_w      = uses && w_prod && (w_rd == rs);
    hit_e_load = hit_e && e_is_load;
    hit_m_load = hit_m && m_is_load;
  end

endmodule

// File: rtl/branch_fwd_ctrl.sv
// Decode-stage forwarding controller for the branch comparator. Tracks a
// shadow copy of destination info for the E, M and W slots, picks a
// forwarding source per branch operand and raises stall when the needed
// value cannot be forwarded yet. Also counts stalled cycles (saturating).
module branch_fwd_ctrl
  import branch_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  branch_fwd_ctrl_if.slave  bus
);

  logic                   e_valid, e_reg_write, e_is_load;
  logic [REG_ADDR_W-1:0]  e_rd;
  logic                   m_valid, m_reg_write, m_is_load;
  logic [REG_ADDR_W-1:0]  m_rd;
  logic                   w_valid, w_reg_write, w_is_load;
  logic [REG_ADDR_W-1:0]  w_rd;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic e_prod, m_prod, w_prod;
  logic hit_e_1, hit_e_load_1, hit_m_1, hit_m_load_1, hit_w_1;
  logic hit_e_2, hit_e_load_2, hit_m_2, hit_m_load_2, hit_w_2;
  logic [1:0] fub_1, fub_2;
  logic stall_c;

  assign e_prod = e_valid && e_reg_write && (e_rd != '0);
  assign m_prod = m_valid && m_reg_write && (m_rd != '0);
  assign w_prod = w_valid && w_reg_write && (w_rd != '0);

  fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs1 (
    .uses(bus.id_uses_rs1), .rs(bus.id_rs1),
    .e_prod(e_prod), .e_is_load(e_is_load), .e_rd(e_rd),
    .m_prod(m_prod), .m_is_load(m_is_load), .m_rd(m_rd),
    .w_prod(w_prod), .w_rd(w_rd),
    .hit_e(hit_e_1), .hit_e_load(hit_e_load_1),
    .hit_m(hit_m_1), .hit_m_load(hit_m_load_1), .hit_w(hit_w_1)
  );

  fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs2 (
    .uses(bus.id_uses_rs2), .rs(bus.id_rs2),
    .e_prod(e_prod), .e_is_load(e_is_load), .e_rd(e_rd),
    .m_prod(m_prod), .m_is_load(m_is_load), .m_rd(m_rd),
    .w_prod(w_prod), .w_rd(w_rd),
    .hit_e(hit_e_2), .hit_e_load(hit_e_load_2),
    .hit_m(hit_m_2), .hit_m_load(hit_m_load_2), .hit_w(hit_w_2)
  );

  // Forwarding selects and stall; flush squashes the stall outright
  always_comb begin
    fub_1   = FUB_RF;
    fub_2   = FUB_RF;
    stall_c = 1'b0;
    if (bus.id_valid) begin
      fub_1 = fub_select(hit_m_1, hit_m_load_1, hit_w_1);
      fub_2 = fub_select(hit_m_2, hit_m_load_2, hit_w_2);
    end
    if (bus.id_valid && !bus.flush) begin
      if (bus.id_is_branch) begin
        stall_c = hit_e_1 || hit_e_2 || hit_m_load_1 || hit_m_load_2;
      end else begin
        stall_c = hit_e_load_1 || hit_e_load_2;
      end
    end
  end

  assign bus.fub_cs_1  = fub_1;
  assign bus.fub_cs_2  = fub_2;
  assign bus.stall     = stall_c;
  assign bus.stall_cnt = stall_cnt_q;

  // Shadow pipeline shift (M/W always advance; E takes a bubble on stall or flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid     <= 1'b0;
      e_reg_write <= 1'b0;
      e_is_load   <= 1'b0;
      e_rd        <= '0;
      m_valid     <= 1'b0;
      m_reg_write <= 1'b0;
      m_is_load   <= 1'b0;
      m_rd        <= '0;
      w_valid     <= 1'b0;
      w_reg_write <= 1'b0;
      w_is_load   <= 1'b0;
      w_rd        <= '0;
    end else begin
      w_valid     <= m_valid;
      w_reg_write <= m_reg_write;
      w_is_load   <= m_is_load;
      w_rd        <= m_rd;
      m_valid     <= e_valid;
      m_reg_write <= e_reg_write;
      m_is_load   <= e_is_load;
      m_rd        <= e_rd;
      e_valid     <= bus.id_valid && !stall_c && !bus.flush;
      e_reg_write <= bus.id_reg_write;
      e_is_load   <= bus.id_is_load;
      e_rd        <= bus.id_rd;
    end
  end

  // Saturating count of stalled cycles since reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Directed bench for branch_fwd_ctrl: a table of per-cycle decode inputs with
// hand-computed selects / stall / stall counter, plus a narrow-counter
// instance driven with repeated load-branch pairs to reach saturation.
module tb_branch_fwd_ctrl;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        br;
    logic        ld;
    logic        rw;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fl;
    logic        chk;
    logic [1:0]  e1;
    logic [1:0]  e2;
    logic        es;
    logic [15:0] ecnt;
  } vec_t;

  logic clk;
  logic rst;
  logic rst_s;
  int   total;
  int   bad;
  vec_t vecs[$];

  branch_fwd_ctrl_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) bus ();
  branch_fwd_ctrl_if #(.REG_ADDR_W(5), .STALL_CNT_W(4))  bus_s ();

  branch_fwd_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  branch_fwd_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(4)) dut_s (
    .clk(clk), .rst(rst_s), .bus(bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, v, b, l, w, input logic [4:0] rd,
                              input logic u1, u2, input logic [4:0] rs1, rs2,
                              input logic fl, chk, input logic [1:0] e1, e2,
                              input logic es, input logic [15:0] ecnt);
    vec_t t;
    t.rst = r;   t.valid = v; t.br = b;   t.ld = l;   t.rw = w;  t.rd = rd;
    t.u1 = u1;   t.u2 = u2;   t.rs1 = rs1; t.rs2 = rs2; t.fl = fl;
    t.chk = chk; t.e1 = e1;   t.e2 = e2;  t.es = es;  t.ecnt = ecnt;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst              = t.rst;
    bus.id_valid     = t.valid;
    bus.id_is_branch = t.br;
    bus.id_is_load   = t.ld;
    bus.id_reg_write = t.rw;
    bus.id_rd        = t.rd;
    bus.id_uses_rs1  = t.u1;
    bus.id_uses_rs2  = t.u2;
    bus.id_rs1       = t.rs1;
    bus.id_rs2       = t.rs2;
    bus.flush        = t.fl;
  endtask

  task automatic applySmall(input logic v, b, l, w, input logic [4:0] rd,
                            input logic [4:0] rs1, rs2);
    bus_s.id_valid     = v;
    bus_s.id_is_branch = b;
    bus_s.id_is_load   = l;
    bus_s.id_reg_write = w;
    bus_s.id_rd        = rd;
    bus_s.id_uses_rs1  = 1'b1;
    bus_s.id_uses_rs2  = b;
    bus_s.id_rs1       = rs1;
    bus_s.id_rs2       = rs2;
    bus_s.flush        = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rst_s = 1'b1;
    applySmall(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    //              rst v  br ld rw rd     u1 u2 rs1    rs2    fl chk e1     e2     es cnt
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0, 1, 1, 5'd5, 5'd6, 0, 0, 2'b00, 2'b00, 0, 16'd0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd5, 5'd6, 0, 1, 2'b00, 2'b00, 0, 16'd0));
    // ADD x5 then BEQ x5,x0: one stall, then ALU forward
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd5, 1, 1, 5'd1, 5'd2, 0, 1, 2'b00, 2'b00, 0, 16'd0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd5, 5'd0, 0, 1, 2'b00, 2'b00, 1, 16'd0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd5, 5'd0, 0, 1, 2'b10, 2'b00, 0, 16'd1));
    // LW x7 then BNE x7,x7: two stalls, then MEM forward on both
    vecs.push_back(mk(0, 1, 0, 1, 1, 5'd7, 1, 0, 5'd2, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd7, 5'd7, 0, 1, 2'b00, 2'b00, 1, 16'd1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd7, 5'd7, 0, 1, 2'b00, 2'b00, 1, 16'd2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd7, 5'd7, 0, 1, 2'b01, 2'b01, 0, 16'd3));
    // ADD x3, SUB x3, BEQ x3: nearest producer (M) wins over W
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd3, 1, 1, 5'd1, 5'd1, 0, 1, 2'b00, 2'b00, 0, 16'd3));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd3, 1, 1, 5'd1, 5'd2, 0, 1, 2'b00, 2'b00, 0, 16'd3));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd3, 5'd0, 0, 1, 2'b10, 2'b00, 1, 16'd3));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd3, 5'd0, 0, 1, 2'b10, 2'b00, 0, 16'd4));
    // Writer to x0 ahead of branches on x0: never a producer
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd0, 1, 0, 5'd0, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd4));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd4));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd4));
    // LW x4 then ADD x8,x4,x1: load-use stall of exactly one cycle
    vecs.push_back(mk(0, 1, 0, 1, 1, 5'd4, 1, 0, 5'd2, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd8, 1, 1, 5'd4, 5'd1, 0, 1, 2'b00, 2'b00, 1, 16'd4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd8, 1, 1, 5'd4, 5'd1, 0, 1, 2'b00, 2'b00, 0, 16'd5));
    // LW x4 then flushed ADD x9,x4,x1: no stall, E becomes a bubble
    vecs.push_back(mk(0, 1, 0, 1, 1, 5'd4, 1, 0, 5'd2, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd5));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd9, 1, 1, 5'd4, 5'd1, 1, 1, 2'b00, 2'b00, 0, 16'd5));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd9, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd5));
    // Invalid decode slot: selects forced to register file even with a W hit
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0, 1, 1, 5'd4, 5'd4, 0, 1, 2'b00, 2'b00, 0, 16'd5));
    // LW x6, BEQ x6,x6 stalls, reset lands mid-stall
    vecs.push_back(mk(0, 1, 0, 1, 1, 5'd6, 1, 0, 5'd2, 5'd0, 0, 1, 2'b00, 2'b00, 0, 16'd5));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd6, 5'd6, 0, 1, 2'b00, 2'b00, 1, 16'd5));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0, 1, 1, 5'd6, 5'd6, 0, 1, 2'b00, 2'b00, 1, 16'd6));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd6, 5'd6, 0, 1, 2'b00, 2'b00, 0, 16'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 1) rst_s = 1'b0;
      applyStimulus(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        checkOutput("fub_cs_1", i, {14'd0, bus.fub_cs_1}, {14'd0, vecs[i].e1});
        checkOutput("fub_cs_2", i, {14'd0, bus.fub_cs_2}, {14'd0, vecs[i].e2});
        checkOutput("stall", i, {15'd0, bus.stall}, {15'd0, vecs[i].es});
        checkOutput("stall_cnt", i, bus.stall_cnt, vecs[i].ecnt);
      end
    end

    // Narrow counter: each LW/BNE x3 group contributes exactly two stalls
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (k == 3 || k == 7 || k == 8) begin
        checkOutput("sat_cnt", k, {12'd0, bus_s.stall_cnt},
                    (2 * k > 15) ? 16'd15 : 16'(2 * k));
      end
      applySmall(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd2, 5'd0);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        applySmall(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7);
      end
    end
    @(negedge clk);
    #1;
    checkOutput("sat_cnt_hold", 20, {12'd0, bus_s.stall_cnt}, 16'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
